// File: rtl/mem_cmd_initiator.sv
// mem_cmd_initiator: serialises one client request onto the 10-bit memory command bus
module mem_cmd_initiator #(
  parameter logic [1:0] DEST_ID = 2'b01,
  parameter logic [1:0] SRC_ID = 2'b10,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  in_bus,
  output logic [9:0]  out_bus,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic        wr_data_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_data_ready,
  output logic        rd_data_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_data_ready,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, HDR, ADDR2, ADDR1, ADDR0, LEN, WDATA, RDATA, DONE} state_t;
  state_t state;
  logic [1:0] op;
  logic [23:0] addr;
  logic [7:0] len, cnt;
  logic [TW-1:0] tmr;
  logic beat_ack, rd_take, waiting, tmr_hit;
  // beat completion, read capture and bus-wait detection; out_bus[8] high masks a just-taken read byte
  always_comb begin
    beat_ack = out_bus[9] & in_bus[8];
    rd_take = (state == RDATA) & ~out_bus[8] & in_bus[9] & rd_data_ready;
    waiting = (out_bus[9] & ~in_bus[8]) | ((state == RDATA) & ~out_bus[8] & ~in_bus[9]);
    tmr_hit = waiting & (tmr == TW'(TIMEOUT_CYCLES - 1));
  end
  // transaction sequencer with registered outputs; out_bus doubles as the write holding register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      out_bus <= '0;
      req_ready <= 1'b1;
      wr_data_ready <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_timeout <= 1'b0;
      op <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      tmr <= '0;
    end else begin
      done <= 1'b0;
      err_timeout <= 1'b0;
      rd_data_valid <= 1'b0;
      tmr <= (beat_ack | rd_take) ? '0 : waiting ? tmr + 1'b1 : tmr;
      if (tmr_hit) begin
        state <= IDLE;
        out_bus <= '0;
        req_ready <= 1'b1;
        busy <= 1'b0;
        wr_data_ready <= 1'b0;
        err_timeout <= 1'b1;
        tmr <= '0;
      end else
        case (state)
          IDLE:
            if (req_valid & req_ready) begin
              op <= req_opcode;
              addr <= req_addr;
              len <= req_len;
              req_ready <= 1'b0;
              busy <= 1'b1;
              out_bus <= {2'b10, DEST_ID, req_opcode, SRC_ID, 2'b00};
              state <= HDR;
            end
          HDR:
            if (beat_ack) begin
              out_bus <= {2'b10, addr[23:16]};
              state <= ADDR2;
            end
          ADDR2:
            if (beat_ack) begin
              out_bus <= {2'b10, addr[15:8]};
              state <= ADDR1;
            end
          ADDR1:
            if (beat_ack) begin
              out_bus <= {2'b10, addr[7:0]};
              state <= ADDR0;
            end
          ADDR0:
            if (beat_ack) begin
              out_bus <= op[1] ? '0 : {2'b10, len};
              state <= op[1] ? DONE : LEN;
            end
          LEN:
            if (beat_ack) begin
              out_bus <= '0;
              cnt <= len;
              wr_data_ready <= op[0];
              state <= op[0] ? WDATA : RDATA;
            end
          WDATA:
            if (wr_data_ready & wr_data_valid) begin
              out_bus <= {2'b10, wr_data};
              wr_data_ready <= 1'b0;
            end else if (beat_ack) begin
              out_bus <= '0;
              cnt <= cnt - 8'd1;
              wr_data_ready <= cnt != 8'd0;
              state <= cnt == 8'd0 ? DONE : WDATA;
            end
          RDATA:
            if (rd_take) begin
              out_bus <= 10'h100;
              rd_data <= in_bus[7:0];
              rd_data_valid <= 1'b1;
              cnt <= cnt - 8'd1;
              state <= cnt == 8'd0 ? DONE : RDATA;
            end else
              out_bus <= '0;
          DONE: begin
            out_bus <= '0;
            busy <= 1'b0;
            req_ready <= 1'b1;
            done <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule
